// File: rtl/butterfly_pkg.sv
// Shared types and helpers for the butterfly load/store unit.
package butterfly_pkg;

    typedef enum logic [1:0] {
        SizeB = 2'b00,
        SizeH = 2'b01,
        SizeW = 2'b10,
        SizeD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } lsu_state_e;

    // Byte strobes for an access of the given size at byte offset off (up to 8 lanes).
    function automatic logic [7:0] lsu_strb(input lsu_size_e size, input logic [2:0] off);
        logic [7:0] strb;
        unique case (size)
            SizeB:   strb = 8'h01 << off;
            SizeH:   strb = 8'h03 << off;
            SizeW:   strb = 8'h0F << off;
            default: strb = 8'hFF;
        endcase
        return strb;
    endfunction

    function automatic logic [3:0] lsu_bytes(input lsu_size_e size);
        logic [3:0] n;
        unique case (size)
            SizeB:   n = 4'd1;
            SizeH:   n = 4'd2;
            SizeW:   n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for stores and extract/extend for loads.
module lsu_align
    import butterfly_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  lsu_size_e                   size_i,
    input  logic [$clog2(XLEN/8)-1:0]   off_i,
    input  logic                        unsigned_i,
    input  logic [XLEN-1:0]             wdata_i,
    input  logic [XLEN-1:0]             rdata_i,
    output logic [XLEN-1:0]             lane_wdata_o,
    output logic [XLEN/8-1:0]           wstrb_o,
    output logic [XLEN-1:0]             rdata_ext_o
);

    localparam int unsigned NB = XLEN / 8;

    logic [7:0]      strb8;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign;

    assign strb8   = lsu_strb(size_i, 3'(off_i));
    assign wstrb_o = strb8[NB-1:0];
    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        lane_wdata_o = wdata_i;
        mask         = '1;
        sign         = 1'b0;
        unique case (size_i)
            SizeB: begin
                lane_wdata_o = {NB{wdata_i[7:0]}};
                mask         = XLEN'(8'hFF);
                sign         = shifted[7];
            end
            SizeH: begin
                lane_wdata_o = {(XLEN/16){wdata_i[15:0]}};
                mask         = XLEN'(16'hFFFF);
                sign         = shifted[15];
            end
            SizeW: begin
                lane_wdata_o = {(XLEN/32){wdata_i[31:0]}};
                mask         = XLEN'(32'hFFFF_FFFF);
                sign         = shifted[31];
            end
            default: begin
                lane_wdata_o = wdata_i;
                mask         = '1;
                sign         = 1'b0;
            end
        endcase
        // Bits above the access width become copies of its sign bit on signed loads.
        rdata_ext_o = (shifted & mask) | ((sign & ~unsigned_i) ? ~mask : '0);
    end

endmodule

// File: rtl/butterfly_lsu.sv
// Single-outstanding load/store unit between EX/MEM and the data-memory port.
// Optional BUTTERFLY_LSU_MISALIGN_TRAP_EN reports misaligned accesses instead of truncating them.
module butterfly_lsu
    import butterfly_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned RD_W           = 5,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  lsu_size_e         req_size_i,
    input  logic              req_unsigned_i,
    input  logic [RD_W-1:0]   req_rd_i,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic [RD_W-1:0]   rsp_rd_o,
    output logic              rsp_err_o,
    output logic              stall_o,
    output logic              dmem_valid_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [XLEN/8-1:0] dmem_wstrb_o,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    input  logic              dmem_ready_i
);

    localparam int unsigned NB     = XLEN / 8;
    localparam int unsigned OFF_W  = $clog2(NB);
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TmoEn  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             we_q, unsigned_q;
    logic [XLEN-1:0]  addr_q, wdata_q, rdata_q;
    lsu_size_e        size_q;
    logic [RD_W-1:0]  rd_q;

    logic [3:0]       req_bytes;
    logic [XLEN-1:0]  req_addr_eff;
    logic             trap;

    assign req_bytes    = lsu_bytes(req_size_i);
    assign req_addr_eff = req_addr_i & ~XLEN'(req_bytes - 4'd1);

`ifdef BUTTERFLY_LSU_MISALIGN_TRAP_EN
    logic [4:0] span;
    assign span = 5'(req_addr_i[OFF_W-1:0]) + 5'(req_bytes);
    assign trap = (|(req_addr_i[3:0] & (req_bytes - 4'd1))) | (span > 5'(NB));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    cnt_d   = '0;
                    err_d   = trap;
                    state_d = trap ? StResp : StBus;
                end
            end
            StBus: begin
                // A ready in the final timeout cycle still completes the access normally.
                if (dmem_ready_i) begin
                    state_d = StResp;
                end else if (TmoEn && (cnt_q == CntMax)) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            size_q     <= SizeB;
            rd_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (state_q == StIdle && req_valid_i) begin
                we_q       <= req_we_i;
                unsigned_q <= req_unsigned_i;
                addr_q     <= req_addr_eff;
                wdata_q    <= req_wdata_i;
                size_q     <= req_size_i;
                rd_q       <= req_rd_i;
            end
            if (state_q == StBus && dmem_ready_i) begin
                rdata_q <= dmem_rdata_i;
            end
        end
    end

    logic [XLEN-1:0] lane_wdata, rdata_ext;
    logic [NB-1:0]   lane_strb;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .size_i       (size_q),
        .off_i        (addr_q[OFF_W-1:0]),
        .unsigned_i   (unsigned_q),
        .wdata_i      (wdata_q),
        .rdata_i      (rdata_q),
        .lane_wdata_o (lane_wdata),
        .wstrb_o      (lane_strb),
        .rdata_ext_o  (rdata_ext)
    );

    // Every output is held low while reset is asserted, whatever state the FSM is in.
    logic in_bus, in_resp;
    assign in_bus  = !rst_i && (state_q == StBus);
    assign in_resp = !rst_i && (state_q == StResp);

    assign req_ready_o  = !rst_i && (state_q == StIdle);
    assign stall_o      = !rst_i && (state_q != StIdle);
    assign dmem_valid_o = in_bus;
    assign dmem_we_o    = in_bus & we_q;
    assign dmem_addr_o  = in_bus ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign dmem_wdata_o = in_bus ? lane_wdata : '0;
    assign dmem_wstrb_o = (in_bus && we_q) ? lane_strb : '0;
    assign rsp_valid_o  = in_resp;
    assign rsp_err_o    = in_resp & err_q;
    assign rsp_rd_o     = in_resp ? rd_q : '0;
    assign rsp_rdata_o  = (in_resp && !we_q && !err_q) ? rdata_ext : '0;

endmodule

// File: tb/tb_butterfly_lsu.sv
// Self-checking bench for butterfly_lsu: directed cases then randomized accesses vs a byte model.
module tb_butterfly_lsu;
    import butterfly_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RD_W = 5;
    localparam int unsigned TMO  = 4;
`ifdef BUTTERFLY_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0, req_ready;
    logic            req_we = 1'b0, req_unsigned = 1'b0;
    logic [31:0]     req_addr = '0, req_wdata = '0;
    lsu_size_e       req_size = SizeW;
    logic [4:0]      req_rd = '0;
    logic            rsp_valid, rsp_err, stall;
    logic [31:0]     rsp_rdata;
    logic [4:0]      rsp_rd;
    logic            dmem_valid, dmem_we;
    logic [31:0]     dmem_addr, dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic [31:0]     dmem_rdata = '0;
    logic            dmem_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    butterfly_lsu #(
        .XLEN           (XLEN),
        .RD_W           (RD_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_rd_i       (req_rd),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_rd_o       (rsp_rd),
        .rsp_err_o      (rsp_err),
        .stall_o        (stall),
        .dmem_valid_o   (dmem_valid),
        .dmem_we_o      (dmem_we),
        .dmem_addr_o    (dmem_addr),
        .dmem_wdata_o   (dmem_wdata),
        .dmem_wstrb_o   (dmem_wstrb),
        .dmem_rdata_i   (dmem_rdata),
        .dmem_ready_i   (dmem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access. Called just after a negedge with the LSU idle.
    // delay = bus cycles before ready; delay >= TMO means the bus never answers.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input lsu_size_e size, input bit uns, input logic [4:0] rd,
                          input logic [31:0] word, input int delay);
        int          n, off, cycles;
        bit          misal, trap, tmo;
        logic [31:0] eff, exp_wd, exp_ld;
        logic [3:0]  exp_strb;
        longint      val;

        n      = 1 << int'(size);
        misal  = ((addr % n) != 0) || ((addr % 4) + n > 4);
        trap   = TRAP && misal;
        eff    = addr - (addr % n);
        off    = eff % 4;
        exp_strb = we ? 4'(((1 << n) - 1) << off) : 4'h0;
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % n) +: 8];
        val = (longint'(word) >> (8 * off)) & ((64'sd1 <<< (8 * n)) - 1);
        if (!uns && val[8*n-1]) val = val - (64'sd1 <<< (8 * n));
        exp_ld = val[31:0];
        tmo    = !trap && (delay >= int'(TMO));
        cycles = (delay < int'(TMO)) ? delay + 1 : int'(TMO);

        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
        req_unsigned = uns; req_rd = rd; req_valid = 1'b1;
        #1;
        chk("req_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        // Scramble the request lines to prove the LSU latched them.
        req_valid = 1'b0; req_we = $urandom; req_addr = $urandom; req_wdata = $urandom;
        req_size = lsu_size_e'($urandom_range(0, 3)); req_unsigned = $urandom; req_rd = $urandom;
        if (!trap) begin
            for (int c = 0; c < cycles; c++) begin
                chk("dmem_valid", dmem_valid, 1);
                chk("dmem_we", dmem_we, we);
                chk("dmem_addr", dmem_addr, {eff[31:2], 2'b00});
                chk("dmem_wstrb", dmem_wstrb, exp_strb);
                if (we) chk("dmem_wdata", dmem_wdata, exp_wd);
                chk("stall_bus", stall, 1);
                chk("rsp_valid_bus", rsp_valid, 0);
                dmem_ready = (c == delay);
                dmem_rdata = (c == delay) ? word : 32'($urandom);
                @(negedge clk);
                dmem_ready = 1'b0;
                dmem_rdata = $urandom;
            end
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, tmo || trap);
        chk("rsp_rdata", rsp_rdata, (we || tmo || trap) ? 32'h0 : exp_ld);
        chk("rsp_rd", rsp_rd, rd);
        chk("dmem_valid_resp", dmem_valid, 0);
        chk("stall_resp", stall, 1);
        @(negedge clk);
        chk("rsp_valid_after", rsp_valid, 0);
        chk("stall_after", stall, 0);
        chk("req_ready_after", req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_stall", stall, 0);
        chk("rst_dmem_valid", dmem_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_wstrb", dmem_wstrb, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 1);
        @(negedge clk);

        // Directed cases.
        access(1'b1, 32'h100, 32'hDEADBEEF, SizeW, 1'b0, 5'd1, 32'h0, 0);
        access(1'b0, 32'h103, 32'h0, SizeB, 1'b0, 5'd2, 32'h8000_0000, 0);
        access(1'b0, 32'h103, 32'h0, SizeB, 1'b1, 5'd3, 32'h8000_0000, 1);
        access(1'b1, 32'h102, 32'h0000_1234, SizeH, 1'b0, 5'd4, 32'h0, 0);
        access(1'b0, 32'h100, 32'h0, SizeW, 1'b0, 5'd5, 32'h1234_5678, 99);
        access(1'b0, 32'h100, 32'h0, SizeW, 1'b0, 5'd6, 32'hCAFE_F00D, 3);
        access(1'b0, 32'h102, 32'h0, SizeW, 1'b0, 5'd7, 32'hA5A5_5A5A, 0);
        access(1'b0, 32'h102, 32'h0, SizeH, 1'b0, 5'd8, 32'h9ABC_0000, 2);

        // Reset pulsed while the bus is stalled.
        req_we = 1'b0; req_addr = 32'h200; req_size = SizeW; req_unsigned = 1'b0;
        req_rd = 5'd9; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_dmem_valid", dmem_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_dmem_valid", dmem_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_dmem_valid", dmem_valid, 0);
        chk("after_rst_stall", stall, 0);
        for (int i = 0; i < 3; i++) begin
            chk("after_rst_no_rsp", rsp_valid, 0);
            @(negedge clk);
        end
        access(1'b0, 32'h200, 32'h0, SizeW, 1'b0, 5'd10, 32'h0BAD_F00D, 1);

        // Randomized accesses.
        for (int t = 0; t < 200; t++) begin
            access(1'($urandom), 32'h300 + 32'($urandom_range(0, 15)), 32'($urandom),
                   lsu_size_e'($urandom_range(0, 2)), 1'($urandom), 5'($urandom),
                   32'($urandom), int'($urandom_range(0, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
